mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath variant. Sequences the shared ALU, unified memory, IR, PC and register file across 3-5 cycles per instruction. Drives every datapath select and write enable from the current state and opcode. Stalls on a memory ready handshake and flags illegal opcodes and memory timeouts.

---
 rtl/mips_ctrl_pkg.sv | 61 ++++++
 rtl/mips_ctrl_decode.sv | 78 +++++++
 rtl/mips_multicycle_ctrl.sv | 135 +++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, state encodings, datapath select codes and the strobe bundle
// for the multi-cycle MIPS control FSM.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // S_IEXEC/S_IWB stay reserved even when the immediate ALU path is compiled out.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_IEXEC   = 4'd10,
        S_IWB     = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// State-to-strobe table for the multi-cycle MIPS datapath (purely combinational).
// IEXEC/IWB rows exist only when IMM_ALU_EN is defined.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // PC+4 and IR only commit once memory has actually delivered the word
                ctrl.pc_write  = mem_ready;
                ctrl.ir_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef IMM_ALU_EN
            S_IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_IWB: begin
                ctrl.reg_write = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequencing, memory wait
// timeout, illegal-opcode and retire flags. IMM_ALU_EN adds the ADDI path.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int STATE_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
    output logic               mem_err,
    output logic               instr_done,
    output logic [STATE_W-1:0] state
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    state_t            state_q;
    state_t            state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              mem_err_q;
    logic              stalled;
    logic              timeout;
    logic              illegal_dec;
    logic              retire;
    ctrl_t             ctrl;

    assign stalled = is_wait_state(state_q) && !mem_ready;
    // MAX_WAIT of zero disables the abort; the counter then just sits at zero.
    assign timeout = (MAX_WAIT != 0) && stalled && (wait_cnt == WAIT_MAX);

    always_comb begin
        state_nxt   = state_q;
        illegal_dec = 1'b0;
        retire      = 1'b0;
        case (state_q)
            S_FETCH:   if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_LW, OP_SW: state_nxt = S_MEMADDR;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
`ifdef IMM_ALU_EN
                    OP_ADDI:      state_nxt = S_IEXEC;
`endif
                    default: begin
                        state_nxt   = S_FETCH;
                        illegal_dec = 1'b1;
                    end
                endcase
            end
            S_MEMADDR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready) begin
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end
            end
            S_EXEC:    state_nxt = S_RWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
`ifdef IMM_ALU_EN
            S_IEXEC:   state_nxt = S_IWB;
            S_IWB: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
`endif
            default:   state_nxt = S_FETCH;
        endcase
        if (timeout) state_nxt = S_FETCH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (timeout) mem_err_q <= 1'b1;
            // a FETCH timeout is a retry with no state change, so clear explicitly
            if ((state_nxt != state_q) || timeout)
                wait_cnt <= '0;
            else if (stalled && (wait_cnt != WAIT_MAX))
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    mips_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign illegal_op  = illegal_dec;
    assign instr_done  = retire;
    assign mem_err     = mem_err_q;
    assign state       = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] O_R    = 6'b000000;
    localparam logic [5:0] O_LW   = 6'b100011;
    localparam logic [5:0] O_SW   = 6'b101011;
    localparam logic [5:0] O_BEQ  = 6'b000100;
    localparam logic [5:0] O_J    = 6'b000010;
    localparam logic [5:0] O_ADDI = 6'b001000;
    localparam logic [5:0] O_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       illegal_op, mem_err, instr_done;
    logic [3:0] state;

    mips_multicycle_ctrl #(.MAX_WAIT(15), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .illegal_op(illegal_op), .mem_err(mem_err), .instr_done(instr_done),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
        logic       ill;
        logic       done;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle_n = 0;
    int   done_exp = 0;
    int   done_seen = 0;
    logic err_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h required %0h", name, cycle_n, act, req);
        end
    endtask

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    function automatic logic [15:0] exp_ctrl(input logic [3:0] s, input logic r);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa;
        logic [1:0] srcb, op, ps;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa} = '0;
        srcb = 2'b00; op = 2'b00; ps = 2'b00;
        case (s)
            4'd0:  begin mr = 1'b1; srcb = 2'b01; pcw = r; irw = r; end
            4'd1:  srcb = 2'b11;
            4'd2:  begin sa = 1'b1; srcb = 2'b10; end
            4'd3:  begin mr = 1'b1; iord = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin mw = 1'b1; iord = 1'b1; end
            4'd6:  begin sa = 1'b1; op = 2'b10; end
            4'd7:  begin rw = 1'b1; rd = 1'b1; end
            4'd8:  begin sa = 1'b1; op = 2'b01; pcwc = 1'b1; ps = 2'b01; end
            4'd9:  begin pcw = 1'b1; ps = 2'b10; end
            4'd10: begin sa = 1'b1; srcb = 2'b10; end
            4'd11: rw = 1'b1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, srcb, op, ps};
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        logic [15:0] act;
        if (instr_done === 1'b1) done_seen++;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
            check("state", 32'(state), 32'(e.st));
            check("strobes", 32'(act), 32'(exp_ctrl(e.st, e.rdy)));
            check("illegal_op", 32'(illegal_op), 32'(e.ill));
            check("instr_done", 32'(instr_done), 32'(e.done));
            check("mem_err", 32'(mem_err), 32'(e.err));
        end
        cycle_n++;
    end

    task automatic cyc(input logic r, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic ill, input logic done);
        exp_t e;
        rst = r; opcode = op; mem_ready = rdy;
        e.st = st; e.rdy = rdy; e.ill = ill; e.done = done; e.err = err_exp;
        sb.push_back(e);
        if (done) done_exp++;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [5:0] op);
        cyc(1'b0, op, 1'b1, 4'd0, 1'b0, 1'b0);
        cyc(1'b0, op, 1'b1, 4'd1, 1'b0, 1'b0);
    endtask

    task automatic run_r();
        fetch_decode(O_R);
        cyc(1'b0, O_R, 1'b1, 4'd6, 1'b0, 1'b0);
        cyc(1'b0, O_R, 1'b1, 4'd7, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; opcode = O_R;
        @(posedge clk);
        #1;
        // second reset cycle: FETCH decode with mem_ready low
        cyc(1'b1, O_R, 1'b0, 4'd0, 1'b0, 1'b0);

        run_r();

        // FETCH stall, then LW with 3 wait cycles in MEMRD
        cyc(1'b0, O_LW, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc(1'b0, O_LW, 1'b0, 4'd0, 1'b0, 1'b0);
        fetch_decode(O_LW);
        cyc(1'b0, O_LW, 1'b1, 4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, O_LW, 1'b0, 4'd3, 1'b0, 1'b0);
        cyc(1'b0, O_LW, 1'b1, 4'd3, 1'b0, 1'b0);
        cyc(1'b0, O_LW, 1'b1, 4'd4, 1'b0, 1'b1);

        fetch_decode(O_SW);
        cyc(1'b0, O_SW, 1'b1, 4'd2, 1'b0, 1'b0);
        cyc(1'b0, O_SW, 1'b1, 4'd5, 1'b0, 1'b1);

        fetch_decode(O_BEQ);
        cyc(1'b0, O_BEQ, 1'b1, 4'd8, 1'b0, 1'b1);

        fetch_decode(O_J);
        cyc(1'b0, O_J, 1'b1, 4'd9, 1'b0, 1'b1);

        cyc(1'b0, O_BAD, 1'b1, 4'd0, 1'b0, 1'b0);
        cyc(1'b0, O_BAD, 1'b1, 4'd1, 1'b1, 1'b0);

`ifdef IMM_ALU_EN
        fetch_decode(O_ADDI);
        cyc(1'b0, O_ADDI, 1'b1, 4'd10, 1'b0, 1'b0);
        cyc(1'b0, O_ADDI, 1'b1, 4'd11, 1'b0, 1'b1);
`else
        cyc(1'b0, O_ADDI, 1'b1, 4'd0, 1'b0, 1'b0);
        cyc(1'b0, O_ADDI, 1'b1, 4'd1, 1'b1, 1'b0);
`endif

        // ready arrives exactly when the counter reaches MAX_WAIT: completes, no error
        fetch_decode(O_LW);
        cyc(1'b0, O_LW, 1'b1, 4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cyc(1'b0, O_LW, 1'b0, 4'd3, 1'b0, 1'b0);
        cyc(1'b0, O_LW, 1'b1, 4'd3, 1'b0, 1'b0);
        cyc(1'b0, O_LW, 1'b1, 4'd4, 1'b0, 1'b1);

        // 15 stalls tolerated, the 16th aborts back to FETCH
        fetch_decode(O_SW);
        cyc(1'b0, O_SW, 1'b1, 4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cyc(1'b0, O_SW, 1'b0, 4'd5, 1'b0, 1'b0);
        err_exp = 1'b1;

        for (int i = 0; i < 10; i++) run_r();

        // reset in the middle of a stalled store clears the sticky error
        fetch_decode(O_SW);
        cyc(1'b0, O_SW, 1'b1, 4'd2, 1'b0, 1'b0);
        cyc(1'b0, O_SW, 1'b0, 4'd5, 1'b0, 1'b0);
        cyc(1'b1, O_SW, 1'b0, 4'd5, 1'b0, 1'b0);
        err_exp = 1'b0;
        run_r();

        check("instr_done_count", 32'(done_seen), 32'(done_exp));
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
